// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the decode/execute interlock: opcode width,
// load-class opcode encodings and the load-stall FSM state type.
package common_params;

  localparam int unsigned OPCODE_W = 7;

  localparam logic [OPCODE_W-1:0] OPC_LOAD    = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OPC_LOAD_FP = 7'b0000111;

  typedef enum logic {
    HZD_IDLE,
    HZD_LOAD_WAIT
  } hzd_state_t;

endpackage

// File: rtl/hazard_stall_unit_load_class_detect.sv
// Flags opcodes whose result arrives late (integer and FP loads).
module load_class_detect
  import common_params::*;
(
  input  logic [OPCODE_W-1:0] opcode_i,
  output logic                is_load_o
);

  always_comb begin
    is_load_o = (opcode_i == OPC_LOAD) || (opcode_i == OPC_LOAD_FP);
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Decode/execute interlock: load-use and multi-cycle-unit hazards produce a
// PC stall, a registered load-stall window, a bubble strobe and a stall counter.
module hazard_stall_unit
  import common_params::*;
#(
  parameter int unsigned LOAD_LATENCY = 1,
  parameter int unsigned EW_LAYER     = 1,
  parameter int unsigned NUM_SRC      = 2,
  parameter int unsigned PERF_W       = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                dec_valid,
  input  logic                                dec_uses_long,
  input  logic [OPCODE_W-1:0]                 exe_opcode,
  input  logic [(EW_LAYER+1)*OPCODE_W-1:0]    wri_opcode,
  input  logic [NUM_SRC-1:0]                  fwd_from_exe,
  input  logic [NUM_SRC*(EW_LAYER+1)-1:0]     fwd_from_wri,
  input  logic                                long_start,
  input  logic                                long_done,
  input  logic                                flush,
  output logic                                stall_pc,
  output logic                                stall_phase,
  output logic                                bubble,
  output logic                                unit_busy,
  output logic [PERF_W-1:0]                   stall_cycles
);

  localparam int unsigned NL    = EW_LAYER + 1;
  localparam int unsigned CNT_W = (LOAD_LATENCY < 2) ? 1 : $clog2(LOAD_LATENCY + 1);
  localparam logic [CNT_W-1:0] WIN_LEN  = CNT_W'(LOAD_LATENCY);
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(1);

  logic                  ld_exe;
  logic [LOAD_LATENCY:0] ld_wri;
  logic                  load_hazard;
  logic                  unit_hazard;

  hzd_state_t            state_q, state_d;
  logic [CNT_W-1:0]      win_q, win_d;
  logic                  bubble_q, bubble_d;
  logic                  busy_q, busy_d;
  logic [PERF_W-1:0]     perf_q, perf_d;

  load_class_detect u_det_exe (
    .opcode_i  (exe_opcode),
    .is_load_o (ld_exe)
  );

  for (genvar i = 0; i <= LOAD_LATENCY; i++) begin : g_wri
    load_class_detect u_det (
      .opcode_i  (wri_opcode[i*OPCODE_W +: OPCODE_W]),
      .is_load_o (ld_wri[i])
    );
  end

  // Layers past LOAD_LATENCY already hold settled results and never stall.
  if (LOAD_LATENCY < EW_LAYER) begin : g_unused
    logic unused_upper;
    always_comb begin
      unused_upper = ^wri_opcode[NL*OPCODE_W-1:(LOAD_LATENCY+1)*OPCODE_W];
      for (int unsigned s = 0; s < NUM_SRC; s++) begin
        for (int unsigned i = LOAD_LATENCY + 1; i < NL; i++) begin
          unused_upper = unused_upper ^ fwd_from_wri[s*NL+i];
        end
      end
    end
  end

  always_comb begin
    logic hit;
    hit = 1'b0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      hit = hit | (ld_exe & fwd_from_exe[s]);
      for (int unsigned i = 0; i <= LOAD_LATENCY; i++) begin
        hit = hit | (ld_wri[i] & fwd_from_wri[s*NL+i]);
      end
    end
    load_hazard = dec_valid & hit;
  end

  always_comb begin
    unit_hazard = dec_valid & dec_uses_long & busy_q & ~long_done;
    stall_pc    = load_hazard | unit_hazard | (state_q == HZD_LOAD_WAIT);
  end

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    bubble_d = stall_pc & ~flush;
    busy_d   = long_start | (busy_q & ~long_done);
    perf_d   = perf_q;
    if (stall_pc && !(&perf_q)) begin
      perf_d = perf_q + PERF_W'(1);
    end
    if (flush) begin
      state_d = HZD_IDLE;
      win_d   = '0;
    end else begin
      case (state_q)
        HZD_IDLE: begin
          if (load_hazard && (LOAD_LATENCY != 0)) begin
            state_d = HZD_LOAD_WAIT;
            win_d   = WIN_LEN;
          end
        end
        HZD_LOAD_WAIT: begin
          // A fresh hazard on the final window cycle extends rather than closes.
          if (win_q == WIN_LAST) begin
            if (load_hazard) begin
              win_d = WIN_LEN;
            end else begin
              state_d = HZD_IDLE;
              win_d   = '0;
            end
          end else begin
            win_d = win_q - WIN_LAST;
          end
        end
        default: begin
          state_d = HZD_IDLE;
          win_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HZD_IDLE;
      win_q    <= '0;
      bubble_q <= 1'b0;
      busy_q   <= 1'b0;
      perf_q   <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      bubble_q <= bubble_d;
      busy_q   <= busy_d;
      perf_q   <= perf_d;
    end
  end

  assign stall_phase  = (state_q == HZD_LOAD_WAIT);
  assign bubble       = bubble_q;
  assign unit_busy    = busy_q;
  assign stall_cycles = perf_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed and random stimulus for hazard_stall_unit, checked against a
// cycle-level behavioural model of the interlock rules.
module tb_hazard_stall_unit;

  localparam int LL  = 2;
  localparam int EW  = 3;
  localparam int NS  = 2;
  localparam int PW  = 4;
  localparam int NL  = EW + 1;
  localparam int OPW = 7;
  localparam int SAT = (1 << PW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              dec_valid, dec_uses_long;
  logic [OPW-1:0]    exe_opcode;
  logic [NL*OPW-1:0] wri_opcode;
  logic [NS-1:0]     fwd_from_exe;
  logic [NS*NL-1:0]  fwd_from_wri;
  logic              long_start, long_done, flush;
  logic              stall_pc, stall_phase, bubble, unit_busy;
  logic [PW-1:0]     stall_cycles;

  int total = 0;
  int bad   = 0;

  // Model state: remaining stall-window cycles, unit occupancy, pending bubble, count.
  int m_win, m_cnt;
  bit m_busy, m_bub;

  hazard_stall_unit #(
    .LOAD_LATENCY (LL),
    .EW_LAYER     (EW),
    .NUM_SRC      (NS),
    .PERF_W       (PW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .dec_valid     (dec_valid),
    .dec_uses_long (dec_uses_long),
    .exe_opcode    (exe_opcode),
    .wri_opcode    (wri_opcode),
    .fwd_from_exe  (fwd_from_exe),
    .fwd_from_wri  (fwd_from_wri),
    .long_start    (long_start),
    .long_done     (long_done),
    .flush         (flush),
    .stall_pc      (stall_pc),
    .stall_phase   (stall_phase),
    .bubble        (bubble),
    .unit_busy     (unit_busy),
    .stall_cycles  (stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic bit is_ld(logic [OPW-1:0] op);
    return (op == 7'h03) || (op == 7'h07);
  endfunction

  function automatic bit model_ld_hazard();
    bit h = 0;
    logic [OPW-1:0] op;
    for (int s = 0; s < NS; s++) begin
      if (is_ld(exe_opcode) && fwd_from_exe[s]) h = 1;
      for (int i = 0; i <= LL; i++) begin
        op = wri_opcode[i*OPW +: OPW];
        if (is_ld(op) && fwd_from_wri[s*NL+i]) h = 1;
      end
    end
    return dec_valid && h;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_win = 0; m_cnt = 0; m_busy = 0; m_bub = 0;
  endtask

  task automatic clear_in();
    dec_valid = 0; dec_uses_long = 0; exe_opcode = '0; wri_opcode = '0;
    fwd_from_exe = '0; fwd_from_wri = '0;
    long_start = 0; long_done = 0; flush = 0;
  endtask

  task automatic chk_regs(string tag);
    chk({tag, ".stall_phase"}, 32'(stall_phase), 32'(m_win > 0));
    chk({tag, ".bubble"}, 32'(bubble), 32'(m_bub));
    chk({tag, ".unit_busy"}, 32'(unit_busy), 32'(m_busy));
    chk({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(m_cnt));
  endtask

  // Called right after inputs change (posedge+1); returns at the next posedge+1.
  task automatic tick(string tag);
    bit ld, pc;
    #1;
    if (rst) model_reset();
    ld = model_ld_hazard();
    pc = ld || (dec_valid && dec_uses_long && m_busy && !long_done) || (m_win > 0);
    chk({tag, ".stall_pc"}, 32'(stall_pc), 32'(pc));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (pc && m_cnt < SAT) m_cnt++;
      m_bub  = pc && !flush;
      m_busy = long_start ? 1'b1 : (long_done ? 1'b0 : m_busy);
      if (flush) m_win = 0;
      else if (ld && LL > 0 && m_win <= 1) m_win = LL;
      else if (m_win > 0) m_win--;
    end
    #1;
    chk_regs(tag);
  endtask

  task automatic pulse_reset(string tag);
    clear_in();
    rst = 1;
    #1;
    model_reset();
    chk({tag, ".stall_pc"}, 32'(stall_pc), 32'(0));
    chk_regs(tag);
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    rst = 1;
    clear_in();
    model_reset();
    #2;
    chk("reset.stall_pc", 32'(stall_pc), 32'(0));
    chk_regs("reset");
    @(posedge clk);
    #1;
    rst = 0;

    // Load in execute feeding source 1 for one decode cycle.
    exe_opcode = 7'h03; fwd_from_exe = 2'b10; dec_valid = 1;
    tick("ldexe");
    clear_in();
    repeat (3) tick("ldexe_win");
    chk("ldexe.count", 32'(stall_cycles), 32'(3));

    // Load at the last checked layer stalls; the same load one layer further does not.
    pulse_reset("rst1");
    wri_opcode[2*OPW +: OPW] = 7'h07; fwd_from_wri[0*NL+2] = 1; dec_valid = 1;
    tick("wri2");
    clear_in();
    repeat (3) tick("wri2_win");
    wri_opcode[3*OPW +: OPW] = 7'h03; fwd_from_wri[0*NL+3] = 1; dec_valid = 1;
    #1;
    chk("wri3.no_stall", 32'(stall_pc), 32'(0));
    tick("wri3");
    clear_in();
    tick("wri3_after");

    // Multi-cycle unit occupancy, with a completion pulse releasing the stall.
    pulse_reset("rst2");
    long_start = 1;
    tick("long_start");
    long_start = 0; dec_uses_long = 1; dec_valid = 1;
    repeat (4) tick("long_busy");
    long_done = 1;
    #1;
    chk("long_done.bypass", 32'(stall_pc), 32'(0));
    tick("long_done");
    clear_in();
    tick("long_idle");
    chk("long_idle.busy", 32'(unit_busy), 32'(0));

    // Flush aborts an open window.
    pulse_reset("rst3");
    exe_opcode = 7'h03; fwd_from_exe = 2'b01; dec_valid = 1;
    tick("fl_trig");
    clear_in(); flush = 1;
    tick("fl_flush");
    clear_in();
    chk("fl.phase", 32'(stall_phase), 32'(0));
    chk("fl.bubble", 32'(bubble), 32'(0));
    repeat (2) tick("fl_after");

    // Asynchronous reset in the middle of a window.
    exe_opcode = 7'h07; fwd_from_exe = 2'b11; dec_valid = 1;
    tick("ar_trig");
    clear_in();
    tick("ar_mid");
    #2;
    rst = 1;
    #1;
    model_reset();
    chk("ar.stall_pc", 32'(stall_pc), 32'(0));
    chk_regs("ar_async");
    @(posedge clk);
    #1;
    rst = 0;
    exe_opcode = 7'h03; fwd_from_exe = 2'b10; dec_valid = 1;
    tick("ar_retrig");
    clear_in();
    repeat (3) tick("ar_win");

    // Counter saturation.
    pulse_reset("rst4");
    exe_opcode = 7'h03; fwd_from_exe = 2'b01; dec_valid = 1;
    repeat (20) tick("sat");
    chk("sat.hold", 32'(stall_cycles), 32'(SAT));
    clear_in();
    repeat (3) tick("sat_drain");

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      rst           = ($urandom_range(0, 49) == 0);
      dec_valid     = ($urandom_range(0, 9) < 7);
      dec_uses_long = $urandom_range(0, 1);
      for (int i = 0; i <= NL; i++) begin
        logic [OPW-1:0] op;
        case ($urandom_range(0, 3))
          0:       op = 7'h03;
          1:       op = 7'h07;
          default: op = OPW'($urandom);
        endcase
        if (i == NL) exe_opcode = op;
        else wri_opcode[i*OPW +: OPW] = op;
      end
      fwd_from_exe = NS'($urandom & $urandom);
      fwd_from_wri = (NS*NL)'($urandom & $urandom & $urandom);
      long_start   = ($urandom_range(0, 9) == 0);
      long_done    = ($urandom_range(0, 6) == 0);
      flush        = ($urandom_range(0, 11) == 0);
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Pipeline interlock generator between decode and execute.
- Detects load-use hazards on up to NUM_SRC source operands against the execute stage and write-back layers 0..LOAD_LATENCY.
- Detects structural hazards on one multi-cycle functional unit, such as a divider.
- Produces a combinational PC stall, a registered stall-phase window, a bubble-insert strobe and a saturating stall-cycle counter; a pipeline flush can abort a load stall window.

Parameters:
- LOAD_LATENCY, 1: extra cycles a load result needs; sets the stall-phase window length.
- EW_LAYER, 1: highest write-back layer index; LOAD_LATENCY <= EW_LAYER.
- NUM_SRC, 2: source operands checked per decoded instruction.
- PERF_W, 32: stall-cycle counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-high.
- dec_valid  in  1  decode holds a valid instruction.
- dec_uses_long  in  1  decoded instruction needs the multi-cycle unit.
- exe_opcode  in  OPCODE_W  opcode in execute.
- wri_opcode  in  OPCODE_W x (EW_LAYER+1)  opcodes in write-back layers.
- fwd_from_exe  in  NUM_SRC  per source: operand forwarded from execute.
- fwd_from_wri  in  NUM_SRC x (EW_LAYER+1)  per source, per layer: operand forwarded from that layer.
- long_start  in  1  multi-cycle op issued this cycle.
- long_done  in  1  multi-cycle unit result-ready pulse.
- flush  in  1  pipeline flush (branch mispredict/exception).
- stall_pc  out  1  hold PC and fetch/decode registers.
- stall_phase  out  1  registered stall window for pipeline registers.
- bubble  out  1  inject NOP into execute this cycle.
- unit_busy  out  1  multi-cycle unit occupied.
- stall_cycles  out  PERF_W  count of cycles with stall_pc high.

Behaviour:
- Reset values: stall_phase=0, bubble=0, unit_busy=0, stall_cycles=0, FSM=IDLE, window counter=0. stall_pc=0 when there are no hazard inputs.
- Load detection: the load-class opcode decode (load_class_detect) is applied to exe_opcode and to wri_opcode[0..LOAD_LATENCY].
  - load_hazard = dec_valid & OR over s of ( (ld_exe & fwd_from_exe[s]) | OR over i<=LOAD_LATENCY of (ld_wri[i] & fwd_from_wri[s][i]) ).
  - Write-back layers above LOAD_LATENCY are ignored.
- Unit hazard: unit_hazard = dec_valid & dec_uses_long & unit_busy & ~long_done. A completion pulse bypasses the stall in the same cycle.
- unit_busy register:
  - Set by long_start; cleared by long_done.
  - long_start and long_done in the same cycle leaves it at 1.
  - flush does not clear it, because the unit finishes regardless.
- stall_pc is combinational, 0-cycle latency: load_hazard | unit_hazard | (FSM==LOAD_WAIT).
- FSM states: IDLE and LOAD_WAIT.
  - IDLE -> LOAD_WAIT when load_hazard & ~flush; window counter loads LOAD_LATENCY.
  - LOAD_WAIT decrements the counter each cycle and returns to IDLE when counter==1 and no new load_hazard.
  - A new load_hazard on the last window cycle reloads the counter and stays in LOAD_WAIT.
  - With LOAD_LATENCY=0, the FSM never leaves IDLE: combinational stall only.
- stall_phase = (FSM==LOAD_WAIT). It rises the cycle after the trigger and stays high exactly LOAD_LATENCY cycles per trigger.
- bubble registered: next value = stall_pc & ~flush, i.e. one bubble per stalled decode cycle, visible in execute the following cycle.
- flush has priority over everything except reset: FSM->IDLE, counter->0, bubble->0 next cycle.
  - stall_pc may still be high in the flush cycle due to combinational hazards; the pipeline ignores it under flush.
- stall_cycles increments when stall_pc=1 and saturates at all-ones. It is not cleared by flush.
- Reset asserted mid-window: all registers return to reset values immediately (asynchronous). On deassert the FSM is in IDLE.

Decomposition:
- Shared package (common_params): OPCODE_W, load-class opcode constants, and the FSM state enum hzd_state_t {HZD_IDLE, HZD_LOAD_WAIT}.
- One natural sub-module, load_class_detect (opcode -> is_load), instantiated 1 + (LOAD_LATENCY+1) times via generate.

Test Plan:
- LOAD_LATENCY=1: load in exe, fwd_from_exe=2'b10, dec_valid=1 for one cycle -> stall_pc=1 at cycle 0; stall_phase=1 at cycle 1 only; bubble=1 at cycle 1; stall_cycles=2.
- LOAD_LATENCY=2: load in wri[2] with fwd_from_wri[0][2]=1 -> stall; the same load in wri[3] (EW_LAYER=3) -> no stall.
- long_start at cycle 0, dec_uses_long=1 from cycle 1, long_done at cycle 5 -> unit_busy and stall_pc high cycles 1-4, stall_pc=0 at cycle 5, unit_busy=0 at cycle 6.
- Load hazard, then flush on cycle 1 with LOAD_LATENCY=3 -> stall_phase drops at cycle 2, FSM IDLE, bubble=0 at cycle 2.
- rst pulsed mid-LOAD_WAIT with stall_cycles=7 -> all outputs 0 asynchronously; the first hazard after release restarts a full window.
- PERF_W=4 with 20 consecutive stall cycles -> stall_cycles holds 15.
